scroll_sequencer: RTL and testbench



---
 rtl/scroll_sequencer.sv | 132 +++++++++++++
 tb/tb_scroll_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/scroll_sequencer.sv
// Frame-rate controller for the layer compositor: turns vsync falling edges into
// frame ticks and runs the HOLD -> SCROLL -> DONE intro, driving layer offsets.
module scroll_sequencer #(
    parameter int HOLD_FRAMES = 45,
    parameter int STEP        = 5,
    parameter int LIMIT       = -600,
    parameter int BG_DIV      = 2,
    parameter int BG_WRAP     = 160
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic               vsync,
    input  logic               start,
    input  logic               pause,
    output logic signed [11:0] hoffset_fg,
    output logic signed [11:0] hoffset_bg,
    output logic [1:0]         state,
    output logic               done,
    output logic [15:0]        frame_count
);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SCROLL = 2'd1,
        DONE   = 2'd2
    } seq_state_t;

    localparam seq_state_t         INIT_STATE  = (HOLD_FRAMES == 0) ? SCROLL : HOLD;
    localparam logic [15:0]        HOLD_INIT   = 16'(HOLD_FRAMES);
    localparam logic [15:0]        BG_DIV_LAST = 16'(BG_DIV - 1);
    localparam logic signed [12:0] STEP13      = 13'(STEP);
    localparam logic signed [12:0] LIMIT13     = 13'(LIMIT);
    localparam logic signed [11:0] LIMIT12     = 12'(LIMIT);
    localparam logic signed [11:0] BG_MIN      = 12'(-(BG_WRAP - 1));

    seq_state_t         cur_state, next_state;
    logic [15:0]        hold_cnt, hold_cnt_next;
    logic [15:0]        bg_div_cnt, bg_div_next;
    logic signed [11:0] fg_next, bg_next;
    logic               done_next;
    logic [15:0]        count_next;
    logic               vs_d, frame_tick;
    logic signed [12:0] fg_dec;

    // Computed one bit wider so the limit compare cannot wrap around.
    assign fg_dec = $signed({hoffset_fg[11], hoffset_fg}) - STEP13;
    assign state  = cur_state;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            vs_d        <= 1'b1;
            frame_tick  <= 1'b0;
            cur_state   <= INIT_STATE;
            hold_cnt    <= HOLD_INIT;
            bg_div_cnt  <= 16'd0;
            hoffset_fg  <= 12'sd0;
            hoffset_bg  <= 12'sd0;
            done        <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            vs_d        <= vsync;
            frame_tick  <= start ? 1'b0 : (vs_d & ~vsync);
            cur_state   <= next_state;
            hold_cnt    <= hold_cnt_next;
            bg_div_cnt  <= bg_div_next;
            hoffset_fg  <= fg_next;
            hoffset_bg  <= bg_next;
            done        <= done_next;
            frame_count <= count_next;
        end
    end

    always_comb begin
        next_state    = cur_state;
        hold_cnt_next = hold_cnt;
        bg_div_next   = bg_div_cnt;
        fg_next       = hoffset_fg;
        bg_next       = hoffset_bg;
        done_next     = done;
        count_next    = frame_count;

        if (start) begin
            next_state    = INIT_STATE;
            hold_cnt_next = HOLD_INIT;
            bg_div_next   = 16'd0;
            fg_next       = 12'sd0;
            bg_next       = 12'sd0;
            done_next     = 1'b0;
            count_next    = 16'd0;
        end else if (frame_tick) begin
            count_next = frame_count + 16'd1;
            if (!pause) begin
                case (cur_state)
                    HOLD: begin
                        if (hold_cnt == 16'd1) begin
                            hold_cnt_next = 16'd0;
                            next_state    = SCROLL;
                        end else begin
                            hold_cnt_next = hold_cnt - 16'd1;
                        end
                    end
                    SCROLL: begin
                        if (fg_dec <= LIMIT13) begin
                            fg_next    = LIMIT12;
                            next_state = DONE;
                            done_next  = 1'b1;
                        end else begin
                            fg_next = fg_dec[11:0];
                        end
                    end
                    DONE: begin
                        fg_next = LIMIT12;
                    end
                    default: begin
                        next_state = INIT_STATE;
                    end
                endcase

                // Background only drifts once the foreground has started moving.
                if (cur_state == SCROLL || cur_state == DONE) begin
                    if (bg_div_cnt == BG_DIV_LAST) begin
                        bg_div_next = 16'd0;
                        bg_next     = (hoffset_bg == BG_MIN) ? 12'sd0 : hoffset_bg - 12'sd1;
                    end else begin
                        bg_div_next = bg_div_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Self-checking bench for scroll_sequencer: two parameterisations share stimulus and
// are compared against a closed-form model driven by counts of unpaused ticks.
module tb_scroll_sequencer;

    localparam int A_HOLD = 45, A_STEP = 5, A_LIMIT = -600, A_DIV = 2, A_WRAP = 160;
    localparam int B_HOLD = 0,  B_STEP = 7, B_LIMIT = -600, B_DIV = 3, B_WRAP = 8;

    logic               CLK100MHZ = 1'b0;
    logic               CPU_RESETN = 1'b0;
    logic               vsync = 1'b1;
    logic               start = 1'b0;
    logic               pause = 1'b0;
    logic signed [11:0] fg_a, bg_a, fg_b, bg_b;
    logic [1:0]         st_a, st_b;
    logic               dn_a, dn_b;
    logic [15:0]        fc_a, fc_b;

    int checks = 0;
    int errors = 0;
    int ticks_run = 0;
    int frames = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    scroll_sequencer #(
        .HOLD_FRAMES(A_HOLD), .STEP(A_STEP), .LIMIT(A_LIMIT), .BG_DIV(A_DIV), .BG_WRAP(A_WRAP)
    ) dut_a (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .vsync(vsync), .start(start),
        .pause(pause), .hoffset_fg(fg_a), .hoffset_bg(bg_a), .state(st_a), .done(dn_a),
        .frame_count(fc_a)
    );

    scroll_sequencer #(
        .HOLD_FRAMES(B_HOLD), .STEP(B_STEP), .LIMIT(B_LIMIT), .BG_DIV(B_DIV), .BG_WRAP(B_WRAP)
    ) dut_b (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .vsync(vsync), .start(start),
        .pause(pause), .hoffset_fg(fg_b), .hoffset_bg(bg_b), .state(st_b), .done(dn_b),
        .frame_count(fc_b)
    );

    // Reference: n unpaused ticks since restart; scroll ticks are those beyond the hold.
    function automatic int exp_state(int n, int h, int step, int lim);
        if (n < h) return 0;
        if (-step * (n - h) <= lim) return 2;
        return 1;
    endfunction

    function automatic int exp_fg(int n, int h, int step, int lim);
        int raw;
        if (n < h) return 0;
        raw = -step * (n - h);
        return (raw < lim) ? lim : raw;
    endfunction

    function automatic int exp_bg(int n, int h, int dv, int wrap);
        if (n < h) return 0;
        return -(((n - h) / dv) % wrap);
    endfunction

    task automatic check_output(input string tag, input int got, input int expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d (tick %0d)", tag, got, expected, ticks_run);
        end
    endtask

    task automatic check_all();
        check_output("a.state", int'(st_a), exp_state(ticks_run, A_HOLD, A_STEP, A_LIMIT));
        check_output("a.fg", int'(fg_a), exp_fg(ticks_run, A_HOLD, A_STEP, A_LIMIT));
        check_output("a.bg", int'(bg_a), exp_bg(ticks_run, A_HOLD, A_DIV, A_WRAP));
        check_output("a.done", int'(dn_a), int'(exp_state(ticks_run, A_HOLD, A_STEP, A_LIMIT) == 2));
        check_output("a.frames", int'(fc_a), frames);
        check_output("b.state", int'(st_b), exp_state(ticks_run, B_HOLD, B_STEP, B_LIMIT));
        check_output("b.fg", int'(fg_b), exp_fg(ticks_run, B_HOLD, B_STEP, B_LIMIT));
        check_output("b.bg", int'(bg_b), exp_bg(ticks_run, B_HOLD, B_DIV, B_WRAP));
        check_output("b.done", int'(dn_b), int'(exp_state(ticks_run, B_HOLD, B_STEP, B_LIMIT) == 2));
        check_output("b.frames", int'(fc_b), frames);
    endtask

    // One vsync pulse: low for low_len cycles, then high for high_len (>= 2) cycles.
    task automatic apply_stimulus(input int low_len, input int high_len);
        vsync = 1'b0;
        repeat (low_len) @(negedge CLK100MHZ);
        vsync = 1'b1;
        repeat (high_len) @(negedge CLK100MHZ);
        frames = (frames + 1) & 16'hFFFF;
        if (!pause) ticks_run++;
        check_all();
    endtask

    task automatic run_pulses(input int count);
        for (int i = 0; i < count; i++) apply_stimulus(1 + int'($urandom_range(3)), 2 + int'($urandom_range(3)));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        @(negedge CLK100MHZ);
        ticks_run = 0;
        frames = 0;
        check_all();
    endtask

    // Start lands on the very edge where the registered frame tick is high.
    task automatic start_on_tick();
        vsync = 1'b0;
        @(negedge CLK100MHZ);
        start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        ticks_run = 0;
        frames = 0;
        check_all();
        repeat (3) @(negedge CLK100MHZ);
        vsync = 1'b1;
        repeat (3) @(negedge CLK100MHZ);
        check_all();
    endtask

    initial begin
        repeat (3) @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        @(negedge CLK100MHZ);
        check_all();

        $display("[TB] hold, scroll, clamp and background wrap");
        run_pulses(370);

        $display("[TB] pause mid-scroll");
        pulse_start();
        run_pulses(A_HOLD + 20);
        check_output("a.fg_before_pause", int'(fg_a), -100);
        pause = 1'b1;
        run_pulses(10);
        pause = 1'b0;
        run_pulses(1);
        check_output("a.fg_after_pause", int'(fg_a), -105);

        $display("[TB] long vsync low gives a single tick");
        apply_stimulus(50, 3);

        $display("[TB] start coincident with frame tick in DONE");
        run_pulses(130);
        start_on_tick();
        run_pulses(3);

        $display("[TB] reset mid-scroll");
        run_pulses(55);
        CPU_RESETN = 1'b0;
        @(negedge CLK100MHZ);
        ticks_run = 0;
        frames = 0;
        check_all();
        CPU_RESETN = 1'b1;
        @(negedge CLK100MHZ);

        $display("[TB] randomized pause/start traffic");
        for (int i = 0; i < 400; i++) begin
            pause = ($urandom_range(4) == 0);
            if ($urandom_range(40) == 0) pulse_start();
            apply_stimulus(1 + int'($urandom_range(3)), 2 + int'($urandom_range(4)));
        end
        pause = 1'b1;
        pulse_start();
        pause = 1'b0;
        run_pulses(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
